// File: rtl/png_pack_wr.sv
// PNG file writer: merges the IDAT payload stream with the fixed PNG header,
// chunk framing and per-chunk CRC words into byte-addressed big-endian writes.
module png_pack_wr (
  input  logic        clk,
  input  logic        rstn,
  input  logic [9:0]  w_i,
  input  logic [9:0]  h_i,
  input  logic        start_i,
  input  logic [31:0] idat_len_i,
  input  logic        val_i,
  input  logic [31:0] dat_i,
  input  logic [1:0]  num_i,
  input  logic        lst_i,
  input  logic        crc_val_i,
  input  logic [31:0] crc_dat_i,
  input  logic        crc_done_i,
  output logic        wr_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic [1:0]  num_o,
  output logic        done_o,
  output logic [31:0] len_o,
  output logic        err_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned NW = 15;
  localparam int unsigned IW = 4;

  // Non-payload word slots, indexed in ascending file-address order.
  localparam logic [NW-1:0] HDR_MASK  = 15'b000_0110_1111_1111;
  localparam logic [NW-1:0] CRC_MASK  = 15'b100_1001_0000_0000;
  localparam logic [NW-1:0] TAIL_MASK = 15'b011_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_d;

  logic [9:0]      r_w;
  logic [9:0]      r_h;
  logic [DW-1:0]   r_len_l;
  logic [DW-1:0]   r_padr;
  logic [DW-1:0]   r_pcnt;
  logic            r_lst_seen;
  logic [NW-1:0]   r_wmask;
  logic [DW-1:0]   r_crc_idat;
  logic [DW-1:0]   r_crc_ihdr;
  logic [DW-1:0]   r_crc_iend;
  logic [2:0]      r_crc_have;
  logic [1:0]      r_crc_cnt;

  logic            w_start;
  logic            w_pay_acc;
  logic            w_stray;
  logic [DW-1:0]   w_pay_bytes;
  logic [DW-1:0]   w_pcnt_nxt;
  logic            w_len_err;
  logic            w_crc_in;
  logic            w_crc_acc;
  logic            w_crc_extra;
  logic [1:0]      w_crc_slot;
  logic [NW-1:0]   w_elig;
  logic [NW-1:0]   w_pend;
  logic [NW-1:0]   w_crc_pend;
  logic [NW-1:0]   w_sel_src;
  logic [NW-1:0]   w_sel_oh;
  logic [IW-1:0]   w_sel_idx;
  logic            w_hdr_wr;
  logic [DW-1:0]   w_hdr_adr;
  logic [DW-1:0]   w_hdr_dat;
  logic [1:0]      w_hdr_num;

  assign w_start     = (r_state == IDLE) && start_i;
  assign w_pay_acc   = (r_state == BODY) && val_i && !r_lst_seen;
  assign w_stray     = val_i && !w_pay_acc;
  assign w_pay_bytes = DW'(num_i) + DW'(1);
  assign w_pcnt_nxt  = r_pcnt + w_pay_bytes;
  assign w_len_err   = w_pay_acc && lst_i && (w_pcnt_nxt != r_len_l);
  assign w_crc_in    = (r_state == BODY) && crc_val_i;
  assign w_crc_acc   = w_crc_in && (r_crc_cnt != 2'd3);
  assign w_crc_extra = w_crc_in && (r_crc_cnt == 2'd3);
  assign w_crc_slot  = crc_done_i ? 2'd2 : r_crc_cnt;
  assign w_hdr_wr    = !w_pay_acc && (w_sel_oh != '0);

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:    if (start_i) w_state_d = BODY;
      BODY:    if (r_lst_seen && (&r_wmask)) w_state_d = DONE;
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // Pick the next non-payload word: pending CRC words first, else lowest address.
  always_comb begin
    w_elig = '0;
    if (r_state == BODY) begin
      w_elig = HDR_MASK;
      if (r_lst_seen) w_elig = w_elig | TAIL_MASK;
      w_elig[11] = r_crc_have[0];
      w_elig[8]  = r_crc_have[1];
      w_elig[14] = r_crc_have[2];
    end
    w_pend     = w_elig & ~r_wmask;
    w_crc_pend = w_pend & CRC_MASK;
    w_sel_src  = (w_crc_pend != '0) ? w_crc_pend : w_pend;
    w_sel_oh   = w_sel_src & (~w_sel_src + NW'(1));
    w_sel_idx  = '0;
    for (int i = 0; i < int'(NW); i++) begin
      if (w_sel_oh[i]) w_sel_idx = IW'(i);
    end
  end

  // Address / value / byte count of each non-payload slot.
  always_comb begin
    w_hdr_adr = '0;
    w_hdr_dat = '0;
    w_hdr_num = 2'd3;
    case (w_sel_idx)
      4'd0:  begin w_hdr_adr = 32'd0;  w_hdr_dat = 32'h8950_4E47; end
      4'd1:  begin w_hdr_adr = 32'd4;  w_hdr_dat = 32'h0D0A_1A0A; end
      4'd2:  begin w_hdr_adr = 32'd8;  w_hdr_dat = 32'h0000_000D; end
      4'd3:  begin w_hdr_adr = 32'd12; w_hdr_dat = 32'h4948_4452; end
      4'd4:  begin w_hdr_adr = 32'd16; w_hdr_dat = {22'd0, r_w}; end
      4'd5:  begin w_hdr_adr = 32'd20; w_hdr_dat = {22'd0, r_h}; end
      4'd6:  begin w_hdr_adr = 32'd24; w_hdr_dat = 32'h0806_0000; end
      4'd7:  begin w_hdr_adr = 32'd28; w_hdr_dat = 32'h0000_0000; w_hdr_num = 2'd0; end
      4'd8:  begin w_hdr_adr = 32'd29; w_hdr_dat = r_crc_ihdr; end
      4'd9:  begin w_hdr_adr = 32'd33; w_hdr_dat = r_len_l; end
      4'd10: begin w_hdr_adr = 32'd37; w_hdr_dat = 32'h4944_4154; end
      4'd11: begin w_hdr_adr = r_len_l + 32'd41; w_hdr_dat = r_crc_idat; end
      4'd12: begin w_hdr_adr = r_len_l + 32'd45; w_hdr_dat = 32'h0000_0000; end
      4'd13: begin w_hdr_adr = r_len_l + 32'd49; w_hdr_dat = 32'h4945_4E44; end
      4'd14: begin w_hdr_adr = r_len_l + 32'd53; w_hdr_dat = r_crc_iend; end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_d;
  end

  // Registered write port and done pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_o   <= 1'b0;
      adr_o  <= '0;
      dat_o  <= '0;
      num_o  <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= (w_state_d == DONE);
      wr_o   <= w_pay_acc || w_hdr_wr;
      if (w_pay_acc) begin
        adr_o <= r_padr;
        dat_o <= dat_i;
        num_o <= num_i;
      end else if (w_hdr_wr) begin
        adr_o <= w_hdr_adr;
        dat_o <= w_hdr_dat;
        num_o <= w_hdr_num;
      end
    end
  end

  // Per-file context, payload tracking, CRC capture and error flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_w        <= '0;
      r_h        <= '0;
      r_len_l    <= '0;
      len_o      <= '0;
      r_padr     <= '0;
      r_pcnt     <= '0;
      r_lst_seen <= 1'b0;
      r_wmask    <= '0;
      r_crc_idat <= '0;
      r_crc_ihdr <= '0;
      r_crc_iend <= '0;
      r_crc_have <= '0;
      r_crc_cnt  <= '0;
      err_o      <= 1'b0;
    end else if (w_start) begin
      r_w        <= w_i;
      r_h        <= h_i;
      r_len_l    <= idat_len_i;
      len_o      <= idat_len_i + 32'd57;
      r_padr     <= 32'd41;
      r_pcnt     <= '0;
      r_lst_seen <= 1'b0;
      r_wmask    <= '0;
      r_crc_have <= '0;
      r_crc_cnt  <= '0;
      err_o      <= w_stray;
    end else begin
      if (w_pay_acc) begin
        r_padr <= r_padr + w_pay_bytes;
        r_pcnt <= w_pcnt_nxt;
        if (lst_i) r_lst_seen <= 1'b1;
      end
      if (w_hdr_wr) r_wmask <= r_wmask | w_sel_oh;
      if (w_crc_acc) begin
        r_crc_cnt <= r_crc_cnt + 2'd1;
        case (w_crc_slot)
          2'd0:    begin r_crc_idat <= crc_dat_i; r_crc_have[0] <= 1'b1; end
          2'd1:    begin r_crc_ihdr <= crc_dat_i; r_crc_have[1] <= 1'b1; end
          default: begin r_crc_iend <= crc_dat_i; r_crc_have[2] <= 1'b1; end
        endcase
      end
      if (w_stray || w_len_err || w_crc_extra) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_png_pack_wr.sv
// Scoreboard bench for png_pack_wr: expected writes are queued per file and
// matched by a monitor that checks every observed write.
module tb_png_pack_wr;

  logic        clk;
  logic        rstn;
  logic [9:0]  w_i;
  logic [9:0]  h_i;
  logic        start_i;
  logic [31:0] idat_len_i;
  logic        val_i;
  logic [31:0] dat_i;
  logic [1:0]  num_i;
  logic        lst_i;
  logic        crc_val_i;
  logic [31:0] crc_dat_i;
  logic        crc_done_i;
  logic        wr_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [1:0]  num_o;
  logic        done_o;
  logic [31:0] len_o;
  logic        err_o;

  png_pack_wr dut (
    .clk        (clk),
    .rstn       (rstn),
    .w_i        (w_i),
    .h_i        (h_i),
    .start_i    (start_i),
    .idat_len_i (idat_len_i),
    .val_i      (val_i),
    .dat_i      (dat_i),
    .num_i      (num_i),
    .lst_i      (lst_i),
    .crc_val_i  (crc_val_i),
    .crc_dat_i  (crc_dat_i),
    .crc_done_i (crc_done_i),
    .wr_o       (wr_o),
    .adr_o      (adr_o),
    .dat_o      (dat_o),
    .num_o      (num_o),
    .done_o     (done_o),
    .len_o      (len_o),
    .err_o      (err_o)
  );

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [1:0]  num;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] wr_log[$];
  logic [31:0] pay_d[$];
  logic [1:0]  pay_n[$];
  int          n_checks;
  int          n_pass;
  int          n_wr;
  int          done_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: each observed write must match some queued expected write.
  always @(negedge clk) begin
    int hit;
    if (wr_o) begin
      hit = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (exp_q[i].adr == adr_o && exp_q[i].dat == dat_o && exp_q[i].num == num_o) begin
          hit = i;
          break;
        end
      end
      n_checks++;
      n_wr++;
      wr_log.push_back(adr_o);
      if (hit >= 0) begin
        n_pass++;
        exp_q.delete(hit);
      end else begin
        $display("FAIL write: got adr=%0d dat=%h num=%0d, not an expected write", adr_o, dat_o, num_o);
      end
    end
    if (done_o) done_cnt++;
  end

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] n);
    wr_t e;
    e.adr = a;
    e.dat = d;
    e.num = n;
    exp_q.push_back(e);
  endtask

  task automatic push_file(input logic [9:0] w, input logic [9:0] h, input logic [31:0] l,
                           input logic [31:0] ca, input logic [31:0] cb, input logic [31:0] cc);
    logic [31:0] a;
    push(32'd0,  32'h8950_4E47, 2'd3);
    push(32'd4,  32'h0D0A_1A0A, 2'd3);
    push(32'd8,  32'h0000_000D, 2'd3);
    push(32'd12, 32'h4948_4452, 2'd3);
    push(32'd16, {22'd0, w},    2'd3);
    push(32'd20, {22'd0, h},    2'd3);
    push(32'd24, 32'h0806_0000, 2'd3);
    push(32'd28, 32'h0000_0000, 2'd0);
    push(32'd29, cb,            2'd3);
    push(32'd33, l,             2'd3);
    push(32'd37, 32'h4944_4154, 2'd3);
    a = 32'd41;
    for (int k = 0; k < pay_d.size(); k++) begin
      push(a, pay_d[k], pay_n[k]);
      a = a + 32'(pay_n[k]) + 32'd1;
    end
    push(l + 32'd41, ca,            2'd3);
    push(l + 32'd45, 32'h0000_0000, 2'd3);
    push(l + 32'd49, 32'h4945_4E44, 2'd3);
    push(l + 32'd53, cc,            2'd3);
  endtask

  task automatic run_file(input string tag, input logic [9:0] w, input logic [9:0] h,
                          input logic [31:0] l, input int gap,
                          input logic [31:0] ca, input logic [31:0] cb, input logic [31:0] cc,
                          input logic [31:0] exp_len, input logic exp_err);
    int base;
    push_file(w, h, l, ca, cb, cc);
    done_cnt = 0;
    base = wr_log.size();
    @(negedge clk);
    w_i = w; h_i = h; idat_len_i = l; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 0; k < pay_d.size(); k++) begin
      val_i = 1'b1; dat_i = pay_d[k]; num_i = pay_n[k];
      lst_i = (k == pay_d.size() - 1);
      @(negedge clk);
      val_i = 1'b0; lst_i = 1'b0;
      repeat (gap) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    crc_val_i = 1'b1; crc_dat_i = ca;
    @(negedge clk);
    crc_dat_i = cb;
    @(negedge clk);
    crc_dat_i = cc; crc_done_i = 1'b1;
    @(negedge clk);
    crc_val_i = 1'b0; crc_done_i = 1'b0;
    for (int i = 0; i < 200 && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, " first write adr"}, (wr_log.size() > base) ? wr_log[base] : 32'hFFFF_FFFF, 32'd41);
    foreach (exp_q[i]) $display("  %s missing write adr=%0d dat=%h", tag, exp_q[i].adr, exp_q[i].dat);
    check({tag, " missing writes"}, exp_q.size(), 0);
    exp_q.delete();
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " len_o"}, len_o, exp_len);
    check({tag, " err_o"}, err_o, exp_err);
  endtask

  initial begin
    int mark;
    int base;
    n_checks = 0; n_pass = 0; n_wr = 0; done_cnt = 0;
    rstn = 1'b1; w_i = '0; h_i = '0; start_i = 1'b0; idat_len_i = '0;
    val_i = 1'b0; dat_i = '0; num_i = '0; lst_i = 1'b0;
    crc_val_i = 1'b0; crc_dat_i = '0; crc_done_i = 1'b0;

    #1 rstn = 1'b0;
    #2 check("reset outputs", {wr_o, adr_o, dat_o, num_o, done_o, len_o, err_o}, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("idle no writes", n_wr, 0);

    // w=4 h=2 L=8, two full words with gaps
    pay_d = '{32'h1122_3344, 32'h5566_7788};
    pay_n = '{2'd3, 2'd3};
    run_file("basic", 10'd4, 10'd2, 32'd8, 1, 32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'hC3C3_C3C3,
             32'd65, 1'b0);

    // L=5, partial last word
    pay_d = '{32'hCAFE_F00D, 32'hAB00_0000};
    pay_n = '{2'd3, 2'd0};
    run_file("partial", 10'd640, 10'd480, 32'd5, 2, 32'h1357_9BDF, 32'h2468_ACE0, 32'h0F0F_F0F0,
             32'd62, 1'b0);

    // Back-to-back payload from the first BODY cycle
    pay_d = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004};
    pay_n = '{2'd3, 2'd3, 2'd3, 2'd3};
    run_file("contig", 10'd1023, 10'd1, 32'd16, 0, 32'h7777_0001, 32'h7777_0002, 32'h7777_0003,
             32'd73, 1'b0);

    // L=8 declared, 12 bytes sent
    pay_d = '{32'hD0D0_D0D0, 32'hD1D1_D1D1, 32'hD2D2_D2D2};
    pay_n = '{2'd3, 2'd3, 2'd3};
    run_file("overrun", 10'd8, 10'd8, 32'd8, 1, 32'hEEEE_0001, 32'hEEEE_0002, 32'hEEEE_0003,
             32'd65, 1'b1);

    // Reset in the middle of a file
    pay_d.delete(); pay_n.delete();
    push_file(10'd7, 10'd3, 32'd4, 32'h0, 32'h0, 32'h0);
    base = n_wr;
    @(negedge clk);
    w_i = 10'd7; h_i = 10'd3; idat_len_i = 32'd4; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 50 && n_wr < base + 5; i++) @(negedge clk);
    check("writes before reset", (n_wr >= base + 5), 1'b1);
    #1 rstn = 1'b0;
    #1 check("mid-file reset outputs", {wr_o, adr_o, dat_o, num_o, done_o, len_o, err_o}, 0);
    exp_q.delete();
    mark = n_wr;
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("no writes after reset", n_wr, mark);

    pay_d = '{32'h4242_4242};
    pay_n = '{2'd3};
    run_file("after_rst", 10'd7, 10'd3, 32'd4, 0, 32'h5A5A_0001, 32'h5A5A_0002, 32'h5A5A_0003,
             32'd61, 1'b0);

    // Stray payload word in IDLE is flagged and not written
    mark = n_wr;
    @(negedge clk);
    val_i = 1'b1; dat_i = 32'hBAD0_BAD0; num_i = 2'd3;
    @(negedge clk);
    val_i = 1'b0;
    repeat (2) @(negedge clk);
    check("stray err_o", err_o, 1'b1);
    check("stray not written", n_wr, mark);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
